// File: rtl/adder_result_capture.sv
// Registered first-word-fall-through capture FIFO for carry-skip adder results,
// with sticky overflow flag and saturating overflow counter. Optional: ADDER_RESULT_SATURATE_EN.
module adder_result_capture #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_sum,
    input  logic                       in_cout,
    input  logic                       in_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_sum,
    output logic                       out_cout,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sticky_ovf,
    output logic [CNT_W-1:0]           ovf_count,
    input  logic                       clr_status
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full check uses only the level register, so a full FIFO refuses a push even while popping.
    assign in_ready  = (level != LW'(DEPTH)) && !rst;
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry.sum  = in_sum;
        wr_entry.cout = in_cout;
        wr_entry.ovf  = in_ovf;
`ifdef ADDER_RESULT_SATURATE_EN
        if (in_ovf) begin
            wr_entry.sum = in_sum[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
        end
`endif
    end

    // NOTE: the array is reset because out_* must read 0 after reset and it is only DEPTH entries deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign out_sum  = head.sum;
    assign out_cout = head.cout;
    assign out_ovf  = head.ovf;

    // An overflow push in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (push && in_ovf) begin
            sticky_ovf <= 1'b1;
            if (clr_status) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != '1) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_status) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule

// File: tb/tb_adder_result_capture.sv
// Directed self-checking bench for adder_result_capture; a second instance with CNT_W=2
// covers counter saturation. Expected sums follow ADDER_RESULT_SATURATE_EN when defined.
module tb_adder_result_capture;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_cout = 1'b0, in_ovf = 1'b0;
    logic [N-1:0]  in_sum = '0;
    logic          out_ready = 1'b0, clr_status = 1'b0;
    logic          in_ready, out_valid, out_cout, out_ovf, sticky_ovf;
    logic [N-1:0]  out_sum;
    logic [2:0]    level;
    logic [15:0]   ovf_count;

    logic          d2_in_valid = 1'b0, d2_in_ovf = 1'b0, d2_out_ready = 1'b0, d2_clr = 1'b0;
    logic          d2_in_ready, d2_out_valid, d2_out_cout, d2_out_ovf, d2_sticky;
    logic [N-1:0]  d2_out_sum;
    logic [2:0]    d2_level;
    logic [1:0]    d2_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_result_capture #(.N(N), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .level(level), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count), .clr_status(clr_status)
    );

    adder_result_capture #(.N(N), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_sum(32'h8000_0000), .in_cout(1'b0), .in_ovf(d2_in_ovf),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_sum(d2_out_sum), .out_cout(d2_out_cout), .out_ovf(d2_out_ovf),
        .level(d2_level), .sticky_ovf(d2_sticky), .ovf_count(d2_count), .clr_status(d2_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [N-1:0] s, input logic c, input logic o);
        in_valid = 1'b1; in_sum = s; in_cout = c; in_ovf = o;
        step();
        in_valid = 1'b0; in_cout = 1'b0; in_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (level !== 3'd0)     begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0)
            begin n_fail++; $display("FAIL reset_out got=%h/%b/%b exp=0/0/0", out_sum, out_cout, out_ovf); end
        n_checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 16'd0)
            begin n_fail++; $display("FAIL reset_status got=%b/%0d exp=0/0", sticky_ovf, ovf_count); end
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_sum = 32'h0000_0005;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_path got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd5 || level !== 3'd1)
            begin n_fail++; $display("FAIL single_latency got=%b/%h/%0d exp=1/5/1", out_valid, out_sum, level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL single_pop got=%0d/%b exp=0/0", level, out_valid); end
    endtask

    task automatic fill_drain(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b1; in_sum = N'(base + i);
            #1;
            n_checks++; if (in_ready !== (i < 4))
                begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 4)); end
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd4 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL fill_full got=%0d/%b exp=4/0", level, in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b1 || out_sum !== N'(base + k))
                begin n_fail++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", k, out_valid, out_sum, base + k); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL drain_empty got=%0d/%b exp=0/0", level, out_valid); end
    endtask

    task automatic test_fill_and_wrap();
        fill_drain(1, 5);
        fill_drain(5, 4);
    endtask

    task automatic test_back_to_back();
        push_one(32'd100, 1'b0, 1'b0);
        push_one(32'd101, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sum = N'(102 + i);
            #1;
            n_checks++; if (out_sum !== N'(100 + i))
                begin n_fail++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, out_sum, 100 + i); end
            step();
            n_checks++; if (level !== 3'd2)
                begin n_fail++; $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (out_sum !== N'(110 + i))
                begin n_fail++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, out_sum, 110 + i); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got=%0d exp=0", level); end
    endtask

    task automatic test_status();
        logic [N-1:0] exp_a, exp_b, exp_c;
`ifdef ADDER_RESULT_SATURATE_EN
        exp_a = 32'h7FFF_FFFF; exp_b = 32'h7FFF_FFFF; exp_c = 32'h8000_0000;
`else
        exp_a = 32'h8000_0000; exp_b = 32'h8000_0001; exp_c = 32'h7FFF_FFFF;
`endif
        out_ready = 1'b1;
        push_one(32'h8000_0000, 1'b0, 1'b1);
        n_checks++; if (sticky_ovf !== 1'b1 || ovf_count !== 16'd1)
            begin n_fail++; $display("FAIL status_first got=%b/%0d exp=1/1", sticky_ovf, ovf_count); end
        n_checks++; if (out_sum !== exp_a || out_ovf !== 1'b1)
            begin n_fail++; $display("FAIL status_sum_a got=%h/%b exp=%h/1", out_sum, out_ovf, exp_a); end
        clr_status = 1'b1;
        push_one(32'h8000_0001, 1'b0, 1'b1);
        clr_status = 1'b0;
        n_checks++; if (sticky_ovf !== 1'b1 || ovf_count !== 16'd1)
            begin n_fail++; $display("FAIL status_clr_vs_push got=%b/%0d exp=1/1", sticky_ovf, ovf_count); end
        n_checks++; if (out_sum !== exp_b) begin n_fail++; $display("FAIL status_sum_b got=%h exp=%h", out_sum, exp_b); end
        push_one(32'h7FFF_FFFF, 1'b0, 1'b1);
        n_checks++; if (out_sum !== exp_c || ovf_count !== 16'd2)
            begin n_fail++; $display("FAIL status_sum_c got=%h/%0d exp=%h/2", out_sum, ovf_count, exp_c); end
        push_one(32'h0000_1234, 1'b1, 1'b0);
        n_checks++; if (out_sum !== 32'h1234 || out_cout !== 1'b1 || out_ovf !== 1'b0 || ovf_count !== 16'd2)
            begin n_fail++; $display("FAIL status_cout got=%h/%b/%b/%0d exp=1234/1/0/2", out_sum, out_cout, out_ovf, ovf_count); end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 16'd0 || level !== 3'd0)
            begin n_fail++; $display("FAIL status_clear got=%b/%0d/%0d exp=0/0/0", sticky_ovf, ovf_count, level); end
    endtask

    task automatic test_count_saturate();
        d2_out_ready = 1'b1; d2_in_valid = 1'b1; d2_in_ovf = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++; if (d2_count !== 2'((i > 3) ? 3 : i))
                begin n_fail++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, d2_count, (i > 3) ? 3 : i); end
        end
        d2_in_valid = 1'b0; d2_in_ovf = 1'b0;
        n_checks++; if (d2_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got=%b exp=1", d2_sticky); end
        d2_clr = 1'b1;
        step();
        d2_clr = 1'b0; d2_out_ready = 1'b0;
        n_checks++; if (d2_count !== 2'd0 || d2_sticky !== 1'b0)
            begin n_fail++; $display("FAIL sat_clear got=%0d/%b exp=0/0", d2_count, d2_sticky); end
    endtask

    task automatic test_mid_reset();
        push_one(32'hA, 1'b0, 1'b1);
        push_one(32'hB, 1'b0, 1'b0);
        push_one(32'hC, 1'b0, 1'b0);
        n_checks++; if (level !== 3'd3 || sticky_ovf !== 1'b1)
            begin n_fail++; $display("FAIL mid_reset_pre got=%0d/%b exp=3/1", level, sticky_ovf); end
        rst = 1'b1;
        #1;
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || sticky_ovf !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_async got=%0d/%b/%b/%b exp=0/0/0/0", level, out_valid, in_ready, sticky_ovf); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_after got=%0d/%b exp=0/0", level, out_valid); end
        push_one(32'h55, 1'b0, 1'b0);
        n_checks++; if (out_sum !== 32'h55 || level !== 3'd1 || out_valid !== 1'b1)
            begin n_fail++; $display("FAIL mid_reset_fresh got=%h/%0d/%b exp=55/1/1", out_sum, level, out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (level !== 3'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset_no_stale got=%0d/%b exp=0/0", level, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_wrap();
        test_back_to_back();
        test_status();
        test_count_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
